mem_interconnect: RTL and testbench

Parametrised memory-mapped interconnect between the single-cycle datapath's load/store port and N memory/IO regions (data memory, image RAM, peripherals). It generalises the fixed two-way decode and read mux to N regions, each with a programmable base/mask, data width and read latency 0–3. For slow regions it stalls the CPU through a ready handshake. Unmapped accesses are flagged with an error pulse.

---
 rtl/mem_interconnect.sv | 138 +++++++++++++
 tb/tb_mem_interconnect.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interconnect.sv
// Memory-mapped interconnect from the CPU load/store port to N_REG regions.
// Each region has its own base/mask decode, read-data width and read latency (0-3).
module mem_interconnect #(
  parameter int DATA_W = 22,
  parameter int ADDR_W = 22,
  parameter int N_REG  = 2,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE = {22'h000000, 22'h080000},
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK = {22'h3F0000, 22'h380000},
  parameter logic [N_REG*5-1:0]      REG_DW   = {5'd22, 5'd8},
  parameter logic [N_REG*2-1:0]      REG_LAT  = {2'd0, 2'd1}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_adr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [N_REG-1:0]        s_sel,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_REG*DATA_W-1:0] s_rdata
);

  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [ADDR_W-1:0] base_arr [N_REG];
  logic [ADDR_W-1:0] mask_arr [N_REG];
  logic [1:0]        lat_arr  [N_REG];
  logic [DATA_W-1:0] rd_arr   [N_REG];
  logic [N_REG-1:0]  hit;

  logic [0:0]        state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]  reg_idx, reg_idx_n;
  logic [ADDR_W-1:0] adr_q, adr_n;
  logic [IDX_W-1:0]  hit_idx;
  logic              hit_any;

  // Per-region decode and zero-extended read data
  for (genvar g = 0; g < N_REG; g++) begin : g_reg
    localparam int DW_G = int'(REG_DW[g*5 +: 5]);
    logic [DATA_W-1:0] dw_mask;
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
      assign dw_mask[b] = (b < DW_G);
    end
    assign base_arr[g] = REG_BASE[g*ADDR_W +: ADDR_W];
    assign mask_arr[g] = REG_MASK[g*ADDR_W +: ADDR_W];
    assign lat_arr[g]  = REG_LAT[g*2 +: 2];
    assign hit[g]      = (cpu_adr & mask_arr[g]) == (base_arr[g] & mask_arr[g]);
    assign rd_arr[g]   = s_rdata[g*DATA_W +: DATA_W] & dw_mask;
  end

  function automatic logic [N_REG-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REG-1:0] oh;
    for (int i = 0; i < N_REG; i++) oh[i] = (idx == IDX_W'(i));
    return oh;
  endfunction

  // Scan downwards so the lowest matching region wins on overlap
  always_comb begin
    hit_idx = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
    hit_any = |hit;
  end

  assign s_wdata = cpu_wdata;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    reg_idx_n = reg_idx;
    adr_n     = adr_q;
    s_sel     = '0;
    s_we      = 1'b0;
    s_adr     = '0;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = '0;
    if (!reset) begin
      if (state == IDLE) begin
        if (cpu_req && hit_any) begin
          s_sel = onehot(hit_idx);
          s_adr = cpu_adr & ~mask_arr[hit_idx];
          if (cpu_we) begin
            s_we      = 1'b1;
            cpu_ready = 1'b1;
          end else if (lat_arr[hit_idx] == 2'd0) begin
            cpu_ready = 1'b1;
            cpu_rdata = rd_arr[hit_idx];
          end else begin
            state_n   = WAIT;
            cnt_n     = 2'd1;
            reg_idx_n = hit_idx;
            adr_n     = s_adr;
          end
        end else if (cpu_req) begin
          cpu_ready = 1'b1;
          cpu_err   = 1'b1;
        end
      end else begin
        // Slow read in flight: only the latched region matters, not a fresh decode
        s_sel = onehot(reg_idx);
        s_adr = adr_q;
        if (cnt == lat_arr[reg_idx]) begin
          cpu_ready = 1'b1;
          cpu_rdata = rd_arr[reg_idx];
          state_n   = IDLE;
          cnt_n     = 2'd0;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      reg_idx <= '0;
      adr_q   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      reg_idx <= reg_idx_n;
      adr_q   <= adr_n;
    end
  end

endmodule

// File: tb/tb_mem_interconnect.sv
// Bench for mem_interconnect: three regions (fast 22-bit, 8-bit LAT=1, 16-bit LAT=3)
// with behavioural slaves, a reference memory and a scoreboard of expected responses.
module tb_mem_interconnect;

  localparam int DATA_W = 22;
  localparam int ADDR_W = 22;
  localparam int N_REG  = 3;
  localparam logic [N_REG*ADDR_W-1:0] REG_BASE = {22'h100000, 22'h080000, 22'h000000};
  localparam logic [N_REG*ADDR_W-1:0] REG_MASK = {22'h3F0000, 22'h380000, 22'h3F0000};
  localparam logic [N_REG*5-1:0]      REG_DW   = {5'd16, 5'd8, 5'd22};
  localparam logic [N_REG*2-1:0]      REG_LAT  = {2'd3, 2'd1, 2'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0;
  logic cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_adr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic cpu_ready, cpu_err, s_we;
  logic [N_REG-1:0] s_sel;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_wdata;
  logic [N_REG*DATA_W-1:0] s_rdata;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  mem_interconnect #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REG(N_REG),
    .REG_BASE(REG_BASE), .REG_MASK(REG_MASK), .REG_DW(REG_DW), .REG_LAT(REG_LAT)
  ) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .s_sel(s_sel), .s_we(s_we),
    .s_adr(s_adr), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  // Reference view of the regions, independent of the RTL decode
  function automatic int region_of(input logic [21:0] a);
    if ((a & 22'h3F0000) == 22'h000000) return 0;
    if ((a & 22'h380000) == 22'h080000) return 1;
    if ((a & 22'h3F0000) == 22'h100000) return 2;
    return -1;
  endfunction

  function automatic int lat_of(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [21:0] dwm_of(input int r);
    case (r)
      0:       return 22'h3FFFFF;
      1:       return 22'h0000FF;
      default: return 22'h00FFFF;
    endcase
  endfunction

  function automatic logic [21:0] omask_of(input int r);
    return (r == 1) ? 22'h07FFFF : 22'h00FFFF;
  endfunction

  function automatic logic [21:0] pat(input int r, input int i);
    if (r == 0 && i == 5)  return 22'h2ABCDE;
    if (r == 1 && i == 16) return 22'h3FFFA5;
    return 22'(((r + 1) * 32'h0005A5A3) ^ (i * 32'h000137F1));
  endfunction

  // Behavioural slaves: LAT>0 slaves latch s_adr at the end of cycle 0 and
  // return junk until the latency has elapsed
  logic [21:0] smem [N_REG][256];
  logic [21:0] ref_mem [N_REG][256];
  logic [1:0]  scnt [N_REG];
  logic [7:0]  sadr_l [N_REG];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int r = 0; r < N_REG; r++)
        for (int i = 0; i < 256; i++) smem[r][i] <= pat(r, i);
      loaded <= 1'b1;
    end
    for (int r = 0; r < N_REG; r++) begin
      if (reset || !s_sel[r] || cpu_ready) scnt[r] <= 2'd0;
      else if (scnt[r] != 2'd3) scnt[r] <= scnt[r] + 2'd1;
      if (s_sel[r] && scnt[r] == 2'd0) sadr_l[r] <= s_adr[7:0];
      if (loaded && s_sel[r] && s_we) smem[r][s_adr[7:0]] <= s_wdata;
    end
  end

  always_comb begin
    s_rdata = '0;
    for (int r = 0; r < N_REG; r++) begin
      if (lat_of(r) == 0) s_rdata[r*DATA_W +: DATA_W] = smem[r][s_adr[7:0]];
      else if (int'(scnt[r]) >= lat_of(r)) s_rdata[r*DATA_W +: DATA_W] = smem[r][sadr_l[r]];
      else s_rdata[r*DATA_W +: DATA_W] = 22'h2C3A5B;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cpu_ready) rdy_cnt <= rdy_cnt + 1;

  // The CPU must not change its request while stalled
  logic pend = 1'b0;
  logic pend_we;
  logic [21:0] pend_adr;
  always @(posedge clk) begin
    if (pend && cpu_req && !reset)
      assert (cpu_adr == pend_adr && cpu_we == pend_we)
        else $error("[TB] cpu request changed while stalled");
    pend     <= cpu_req && !cpu_ready && !reset;
    pend_adr <= cpu_adr;
    pend_we  <= cpu_we;
  end

  typedef struct {
    logic [21:0] rdata;
    logic        err;
    int          lat;
    logic        chk_rd;
    logic [2:0]  sel;
    logic [21:0] off;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int obs_lat, obs_start, obs_end;
  logic [21:0] obs_rd, obs_sadr0, obs_sadr_rdy;
  logic obs_err, obs_we0, obs_to;
  logic [2:0] obs_sel0;

  task automatic push_expect(input logic we, input logic [21:0] adr, input logic [21:0] wd);
    exp_t x;
    int r;
    r = region_of(adr);
    x.err = (r < 0); x.lat = 0; x.rdata = '0; x.chk_rd = 1'b1; x.sel = '0; x.off = '0;
    if (r >= 0) begin
      x.sel = 3'(1 << r);
      x.off = adr & omask_of(r);
      if (we) begin
        x.chk_rd = 1'b0;
        ref_mem[r][x.off[7:0]] = wd;
      end else begin
        x.lat   = lat_of(r);
        x.rdata = ref_mem[r][x.off[7:0]] & dwm_of(r);
      end
    end
    sb.push_back(x);
  endtask

  task automatic run_access(input logic we, input logic [21:0] adr, input logic [21:0] wd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
    obs_to = 1'b1; obs_start = cyc;
    for (int c = 0; c < 10 && obs_to; c++) begin
      @(negedge clk);
      if (c == 0) begin obs_sel0 = s_sel; obs_we0 = s_we; obs_sadr0 = s_adr; end
      if (cpu_ready) begin
        obs_to = 1'b0; obs_lat = c; obs_rd = cpu_rdata; obs_err = cpu_err;
        obs_sadr_rdy = s_adr; obs_end = cyc;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 22'h100002;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (s_sel !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_sel: got %b want 000", s_sel); end
      n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0", cpu_ready); end
      n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", cpu_err); end
      n_checks++; if (cpu_rdata !== 22'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 0", cpu_rdata); end
    end
    push_expect(1'b0, 22'h100002, '0);
    e = sb.pop_front();
    @(posedge clk); #1 reset = 1'b0;
    obs_to = 1'b1;
    for (int c = 0; c < 10 && obs_to; c++) begin
      @(negedge clk);
      if (c == 0) obs_sel0 = s_sel;
      if (cpu_ready) begin obs_to = 1'b0; obs_lat = c; obs_rd = cpu_rdata; end
    end
    n_checks++; if (obs_to) begin n_fail++; $display("[TB] FAIL post_reset_timeout: no ready within 10 cycles"); end
    n_checks++; if (obs_lat != 3) begin n_fail++; $display("[TB] FAIL post_reset_lat: got %0d want 3", obs_lat); end
    n_checks++; if (obs_sel0 !== 3'b100) begin n_fail++; $display("[TB] FAIL post_reset_sel: got %b want 100", obs_sel0); end
    n_checks++; if (obs_rd !== e.rdata) begin n_fail++; $display("[TB] FAIL post_reset_rdata: got %h want %h", obs_rd, e.rdata); end
    idle_cycle();
  endtask

  task automatic test_lat0_read();
    push_expect(1'b0, 22'h000005, '0);
    run_access(1'b0, 22'h000005, '0);
    e = sb.pop_front();
    n_checks++; if (obs_to || obs_lat != 0) begin n_fail++; $display("[TB] FAIL lat0_ready: got lat %0d (timeout %b) want 0", obs_lat, obs_to); end
    n_checks++; if (obs_rd !== 22'h2ABCDE) begin n_fail++; $display("[TB] FAIL lat0_rdata: got %h want 2abcde", obs_rd); end
    n_checks++; if (obs_sel0 !== 3'b001) begin n_fail++; $display("[TB] FAIL lat0_sel: got %b want 001", obs_sel0); end
    n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL lat0_err: got %b want 0", obs_err); end
  endtask

  task automatic test_narrow_read();
    push_expect(1'b0, 22'h080010, '0);
    run_access(1'b0, 22'h080010, '0);
    e = sb.pop_front();
    n_checks++; if (obs_to || obs_lat != 1) begin n_fail++; $display("[TB] FAIL narrow_lat: got %0d (timeout %b) want 1", obs_lat, obs_to); end
    n_checks++; if (obs_rd !== 22'h0000A5) begin n_fail++; $display("[TB] FAIL narrow_rdata: got %h want 0000a5", obs_rd); end
    n_checks++; if (obs_sadr_rdy !== 22'h000010) begin n_fail++; $display("[TB] FAIL narrow_sadr: got %h want 000010", obs_sadr_rdy); end
    n_checks++; if (obs_sel0 !== 3'b010) begin n_fail++; $display("[TB] FAIL narrow_sel: got %b want 010", obs_sel0); end
  endtask

  task automatic test_write_slow();
    push_expect(1'b1, 22'h080003, 22'h0000FF);
    run_access(1'b1, 22'h080003, 22'h0000FF);
    e = sb.pop_front();
    n_checks++; if (obs_to || obs_lat != 0) begin n_fail++; $display("[TB] FAIL wr_ready: got lat %0d (timeout %b) want 0", obs_lat, obs_to); end
    n_checks++; if (obs_we0 !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_we: got %b want 1", obs_we0); end
    n_checks++; if (obs_sel0 !== 3'b010) begin n_fail++; $display("[TB] FAIL wr_sel: got %b want 010", obs_sel0); end
    n_checks++; if (obs_sadr0 !== 22'h000003) begin n_fail++; $display("[TB] FAIL wr_sadr: got %h want 000003", obs_sadr0); end
    push_expect(1'b0, 22'h080003, '0);
    run_access(1'b0, 22'h080003, '0);
    e = sb.pop_front();
    n_checks++; if (obs_to || obs_lat != 1) begin n_fail++; $display("[TB] FAIL wr_rb_lat: got %0d (timeout %b) want 1", obs_lat, obs_to); end
    n_checks++; if (obs_rd !== 22'h0000FF) begin n_fail++; $display("[TB] FAIL wr_rb_rdata: got %h want 0000ff", obs_rd); end
  endtask

  task automatic test_unmapped();
    for (int w = 0; w < 2; w++) begin
      push_expect(1'(w), 22'h200000, 22'h155AA5);
      run_access(1'(w), 22'h200000, 22'h155AA5);
      e = sb.pop_front();
      n_checks++; if (obs_to || obs_lat != 0) begin n_fail++; $display("[TB] FAIL miss_ready(we=%0d): got lat %0d (timeout %b) want 0", w, obs_lat, obs_to); end
      n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("[TB] FAIL miss_err(we=%0d): got %b want 1", w, obs_err); end
      n_checks++; if (obs_rd !== 22'h0) begin n_fail++; $display("[TB] FAIL miss_rdata(we=%0d): got %h want 0", w, obs_rd); end
      n_checks++; if (obs_sel0 !== 3'b000) begin n_fail++; $display("[TB] FAIL miss_sel(we=%0d): got %b want 000", w, obs_sel0); end
      n_checks++; if (obs_we0 !== 1'b0) begin n_fail++; $display("[TB] FAIL miss_we(we=%0d): got %b want 0", w, obs_we0); end
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [21:0] adrs [6];
    logic        wes  [6];
    logic [21:0] wds  [6];
    int first, exp_cycles;
    adrs = '{22'h100007, 22'h000009, 22'h080020, 22'h080020, 22'h10000A, 22'h10000A};
    wes  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    wds  = '{22'h0, 22'h0, 22'h2C3D11, 22'h0, 22'h3ABCDE, 22'h0};
    exp_cycles = 0;
    first = 0;
    for (int k = 0; k < 6; k++) begin
      push_expect(wes[k], adrs[k], wds[k]);
      run_access(wes[k], adrs[k], wds[k]);
      if (k == 0) first = obs_start;
      e = sb.pop_front();
      exp_cycles += e.lat + 1;
      n_checks++; if (obs_to || obs_lat != e.lat) begin n_fail++; $display("[TB] FAIL b2b_lat[%0d]: got %0d (timeout %b) want %0d", k, obs_lat, obs_to, e.lat); end
      if (e.chk_rd) begin
        n_checks++; if (obs_rd !== e.rdata) begin n_fail++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", k, obs_rd, e.rdata); end
      end
      n_checks++; if (obs_sel0 !== e.sel) begin n_fail++; $display("[TB] FAIL b2b_sel[%0d]: got %b want %b", k, obs_sel0, e.sel); end
    end
    n_checks++; if (obs_end - first + 1 != exp_cycles) begin n_fail++; $display("[TB] FAIL b2b_cycles: got %0d want %0d", obs_end - first + 1, exp_cycles); end
    idle_cycle();
  endtask

  task automatic test_req_drop();
    int got, pulses;
    logic [21:0] rd;
    push_expect(1'b0, 22'h100004, '0);
    e = sb.pop_front();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 22'h100004;
    got = -1; pulses = 0; rd = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ready) begin
        pulses++;
        if (got < 0) begin got = c; rd = cpu_rdata; end
      end
      if (c == 0) begin @(posedge clk); #1 cpu_req = 1'b0; end
    end
    n_checks++; if (got != 3) begin n_fail++; $display("[TB] FAIL drop_lat: got %0d want 3", got); end
    n_checks++; if (rd !== e.rdata) begin n_fail++; $display("[TB] FAIL drop_rdata: got %h want %h", rd, e.rdata); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("[TB] FAIL drop_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_mixed_random();
    int n_req, rdy0, rsel;
    logic [21:0] a, wd;
    logic w;
    n_req = 0;
    idle_cycle();
    rdy0 = rdy_cnt;
    for (int k = 0; k < 40; k++) begin
      rsel = $urandom_range(0, 3);
      a = 22'($urandom_range(0, 15));
      case (rsel)
        1:       a = a | 22'h080000;
        2:       a = a | 22'h100000;
        3:       a = a | 22'h200000;
        default: a = a;
      endcase
      w  = 1'($urandom_range(0, 1));
      wd = 22'($urandom);
      push_expect(w, a, wd);
      run_access(w, a, wd);
      n_req++;
      e = sb.pop_front();
      n_checks++; if (obs_to || obs_lat != e.lat) begin n_fail++; $display("[TB] FAIL rnd_lat[%0d] adr %h: got %0d (timeout %b) want %0d", k, a, obs_lat, obs_to, e.lat); end
      n_checks++; if (obs_err !== e.err) begin n_fail++; $display("[TB] FAIL rnd_err[%0d] adr %h: got %b want %b", k, a, obs_err, e.err); end
      if (e.chk_rd) begin
        n_checks++; if (obs_rd !== e.rdata) begin n_fail++; $display("[TB] FAIL rnd_rdata[%0d] adr %h: got %h want %h", k, a, obs_rd, e.rdata); end
      end
      n_checks++; if (obs_sel0 !== e.sel) begin n_fail++; $display("[TB] FAIL rnd_sel[%0d] adr %h: got %b want %b", k, a, obs_sel0, e.sel); end
      if (!e.err) begin
        n_checks++; if (obs_sadr0 !== e.off) begin n_fail++; $display("[TB] FAIL rnd_sadr[%0d] adr %h: got %h want %h", k, a, obs_sadr0, e.off); end
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    n_checks++; if (rdy_cnt - rdy0 != n_req) begin n_fail++; $display("[TB] FAIL rnd_ready_count: got %0d want %0d", rdy_cnt - rdy0, n_req); end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 22'h100004;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0 || s_sel !== 3'b100) begin n_fail++; $display("[TB] FAIL abort_c0: got ready %b sel %b want 0 100", cpu_ready, s_sel); end
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_c1: got ready %b want 0", cpu_ready); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0 || s_sel !== 3'b000) begin n_fail++; $display("[TB] FAIL abort_in_reset: got ready %b sel %b want 0 000", cpu_ready, s_sel); end
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0 || s_sel !== 3'b000) begin n_fail++; $display("[TB] FAIL abort_after: got ready %b sel %b want 0 000", cpu_ready, s_sel); end
    push_expect(1'b0, 22'h000007, '0);
    run_access(1'b0, 22'h000007, '0);
    e = sb.pop_front();
    n_checks++; if (obs_to || obs_lat != 0 || obs_rd !== e.rdata) begin n_fail++; $display("[TB] FAIL abort_idle_read: got lat %0d rdata %h want 0 %h", obs_lat, obs_rd, e.rdata); end
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int r = 0; r < N_REG; r++)
      for (int i = 0; i < 256; i++) ref_mem[r][i] = pat(r, i);
    test_reset();
    test_lat0_read();
    test_narrow_read();
    test_write_slow();
    test_unmapped();
    test_back_to_back();
    test_req_drop();
    test_mixed_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
